// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } req_id_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction (I) and a data (D) requester onto one memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed D priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned BURST_LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 i_read,
  input  logic                 i_write,
  input  logic [31:0]          i_address,
  input  logic [BURST_LEN-1:0] i_wdata,
  input  logic [3:0]           i_byte_enable,
  output logic                 i_resp,
  output logic [BURST_LEN-1:0] i_rdata,

  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [31:0]          d_address,
  input  logic [BURST_LEN-1:0] d_wdata,
  input  logic [3:0]           d_byte_enable,
  output logic                 d_resp,
  output logic [BURST_LEN-1:0] d_rdata,

  output logic                 mem_read,
  output logic                 mem_write,
  output logic [31:0]          mem_address,
  output logic [BURST_LEN-1:0] mem_wdata,
  output logic [3:0]           mem_byte_enable,
  input  logic                 mem_resp,
  input  logic [BURST_LEN-1:0] mem_rdata
);

  arb_state_t           state_q;
  logic                 mem_read_q;
  logic                 mem_write_q;
  logic [31:0]          mem_address_q;
  logic [BURST_LEN-1:0] mem_wdata_q;
  logic [3:0]           mem_byte_enable_q;

  logic                 i_pend;
  logic                 d_pend;
  req_id_t              winner;
  logic                 win_read;
  logic                 win_write;
  logic [31:0]          win_address;
  logic [BURST_LEN-1:0] win_wdata;
  logic [3:0]           win_byte_enable;

  assign i_pend = i_read | i_write;
  assign d_pend = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  req_id_t last_grant_q;

  // Reset value marks I as last granted, so the first tie goes to D.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= REQ_I;
    end else if (state_q == IDLE && (i_pend || d_pend)) begin
      last_grant_q <= winner;
    end
  end

  always_comb begin
    winner = REQ_I;
    if (i_pend && d_pend) begin
      winner = (last_grant_q == REQ_D) ? REQ_I : REQ_D;
    end else if (d_pend) begin
      winner = REQ_D;
    end
  end
`else
  always_comb begin
    winner = d_pend ? REQ_D : REQ_I;
  end
`endif

  always_comb begin
    win_read        = i_read;
    win_write       = i_write;
    win_address     = i_address;
    win_wdata       = i_wdata;
    win_byte_enable = i_byte_enable;
    if (winner == REQ_D) begin
      win_read        = d_read;
      win_write       = d_write;
      win_address     = d_address;
      win_wdata       = d_wdata;
      win_byte_enable = d_byte_enable;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= IDLE;
      mem_read_q        <= 1'b0;
      mem_write_q       <= 1'b0;
      mem_address_q     <= '0;
      mem_wdata_q       <= '0;
      mem_byte_enable_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_pend || d_pend) begin
            state_q           <= (winner == REQ_D) ? SERVE_D : SERVE_I;
            // A simultaneous read+write request is issued as a write only.
            mem_read_q        <= win_read & ~win_write;
            mem_write_q       <= win_write;
            mem_address_q     <= win_address;
            mem_wdata_q       <= win_wdata;
            mem_byte_enable_q <= win_byte_enable;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_address     = mem_address_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_byte_enable = mem_byte_enable_q;

  always_comb begin
    i_resp  = (state_q == SERVE_I) && mem_resp;
    d_resp  = (state_q == SERVE_D) && mem_resp;
    i_rdata = i_resp ? mem_rdata : '0;
    d_rdata = d_resp ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter; expectations follow ARB_ROUND_ROBIN_EN.
`timescale 1ns / 1ps
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_read, i_write, d_read, d_write;
  logic [31:0] i_address, d_address, i_wdata, d_wdata;
  logic [3:0]  i_byte_enable, d_byte_enable;
  logic        i_resp, d_resp;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_read, mem_write, mem_resp;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic [3:0]  mem_byte_enable;

  int n_vec;
  int n_err;

  mem_arbiter #(.BURST_LEN(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_read          (i_read),
    .i_write         (i_write),
    .i_address       (i_address),
    .i_wdata         (i_wdata),
    .i_byte_enable   (i_byte_enable),
    .i_resp          (i_resp),
    .i_rdata         (i_rdata),
    .d_read          (d_read),
    .d_write         (d_write),
    .d_address       (d_address),
    .d_wdata         (d_wdata),
    .d_byte_enable   (d_byte_enable),
    .d_resp          (d_resp),
    .d_rdata         (d_rdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ird;
    logic [31:0] iaddr;
    logic        drd;
    logic        dwr;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic [3:0]  dbe;
    logic        mresp;
    logic [31:0] mrdata;
    logic        erd;
    logic        ewr;
    logic [31:0] eaddr;
    logic [31:0] ewd;
    logic [3:0]  ebe;
    logic        eir;
    logic        edr;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic ird, logic [31:0] iaddr, logic drd, logic dwr,
                              logic [31:0] daddr, logic [31:0] dwd, logic [3:0] dbe,
                              logic mresp, logic [31:0] mrdata, logic erd, logic ewr,
                              logic [31:0] eaddr, logic [31:0] ewd, logic [3:0] ebe,
                              logic eir, logic edr);
    vec_t v;
    v.ird = ird;     v.iaddr = iaddr; v.drd = drd;     v.dwr = dwr;
    v.daddr = daddr; v.dwd = dwd;     v.dbe = dbe;     v.mresp = mresp;
    v.mrdata = mrdata;
    v.erd = erd;     v.ewr = ewr;     v.eaddr = eaddr; v.ewd = ewd;
    v.ebe = ebe;     v.eir = eir;     v.edr = edr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string name);
    int cnt;
    cnt = 0;
    while (!(mem_read || mem_write) && cnt < 8) begin
      step();
      cnt++;
    end
    chk(name, 32'(mem_read | mem_write), 32'd1);
  endtask

  localparam logic [31:0] IWD = 32'h1111_1111;
  localparam logic [3:0]  IBE = 4'hC;

  logic exp_d;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    i_address = '0; d_address = '0; i_wdata = IWD; d_wdata = '0;
    i_byte_enable = IBE; d_byte_enable = '0;
    mem_resp = 0; mem_rdata = '0;

    // I read, D write, then I after one idle cycle, then D read+write.
    vecs[0]  = mk(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0,            1, 0, 32'h1000, IWD, IBE, 0, 0);
    vecs[2]  = mk(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0,            1, 0, 32'h1000, IWD, IBE, 0, 0);
    vecs[3]  = mk(1, 32'h1000, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1, 0, 32'h1000, IWD, IBE, 1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF,        0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 32'h100, 0, 1, 32'h200, 32'h12345678, 4'b0011, 0, 0,
                  0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 32'h100, 0, 1, 32'h200, 32'h12345678, 4'b0011, 0, 0,
                  0, 1, 32'h200, 32'h12345678, 4'b0011, 0, 0);
    // D drops its request in the completing cycle; resp must still pulse.
    vecs[9]  = mk(1, 32'h100, 0, 0, 0, 0, 0, 1, 32'hCAFE0000,
                  0, 1, 32'h200, 32'h12345678, 4'b0011, 0, 1);
    vecs[10] = mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0,             1, 0, 32'h100, IWD, IBE, 0, 0);
    vecs[12] = mk(1, 32'h100, 0, 0, 0, 0, 0, 1, 32'h0BADF00D, 1, 0, 32'h100, IWD, IBE, 1, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 1, 1, 32'h40, 32'hAAAA5555, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 1, 1, 32'h40, 32'hAAAA5555, 4'hF, 0, 0,
                  0, 1, 32'h40, 32'hAAAA5555, 4'hF, 0, 0);
    vecs[16] = mk(0, 0, 1, 1, 32'h40, 32'hAAAA5555, 4'hF, 1, 32'h0,
                  0, 1, 32'h40, 32'hAAAA5555, 4'hF, 0, 1);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", 32'(mem_byte_enable), 0);
    chk("rst_i_resp", 32'(i_resp), 0);
    chk("rst_d_resp", 32'(d_resp), 0);
    rst = 1'b1;
    step();

    for (int k = 0; k < 18; k++) begin
      i_read = vecs[k].ird;   i_address = vecs[k].iaddr;
      d_read = vecs[k].drd;   d_write = vecs[k].dwr;   d_address = vecs[k].daddr;
      d_wdata = vecs[k].dwd;  d_byte_enable = vecs[k].dbe;
      mem_resp = vecs[k].mresp; mem_rdata = vecs[k].mrdata;
      @(negedge clk);
      chk($sformatf("v%0d_mem_read", k), 32'(mem_read), 32'(vecs[k].erd));
      chk($sformatf("v%0d_mem_write", k), 32'(mem_write), 32'(vecs[k].ewr));
      if (vecs[k].erd || vecs[k].ewr) begin
        chk($sformatf("v%0d_mem_address", k), mem_address, vecs[k].eaddr);
        chk($sformatf("v%0d_mem_wdata", k), mem_wdata, vecs[k].ewd);
        chk($sformatf("v%0d_mem_be", k), 32'(mem_byte_enable), 32'(vecs[k].ebe));
      end
      chk($sformatf("v%0d_i_resp", k), 32'(i_resp), 32'(vecs[k].eir));
      chk($sformatf("v%0d_d_resp", k), 32'(d_resp), 32'(vecs[k].edr));
      chk($sformatf("v%0d_i_rdata", k), i_rdata, vecs[k].eir ? vecs[k].mrdata : 32'h0);
      chk($sformatf("v%0d_d_rdata", k), d_rdata, vecs[k].edr ? vecs[k].mrdata : 32'h0);
      step();
    end
    mem_resp = 0;

    // Reset in the middle of an I transaction.
    i_read = 1; i_address = 32'h300;
    wait_grant("rst_mid_grant");
    rst = 1'b0;
    mem_resp = 1; mem_rdata = 32'h5555AAAA;
    #1;
    chk("rst_mid_mem_read", 32'(mem_read), 0);
    chk("rst_mid_mem_address", mem_address, 0);
    chk("rst_mid_mem_wdata", mem_wdata, 0);
    chk("rst_mid_mem_be", 32'(mem_byte_enable), 0);
    chk("rst_mid_i_resp", 32'(i_resp), 0);
    chk("rst_mid_i_rdata", i_rdata, 0);
    i_read = 0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_i_resp", 32'(i_resp), 0);
    chk("post_rst_d_resp", 32'(d_resp), 0);
    chk("post_rst_i_rdata", i_rdata, 0);
    step();
    mem_resp = 0;
    @(negedge clk);
    chk("post_rst_idle_rd", 32'(mem_read), 0);
    chk("post_rst_idle_wr", 32'(mem_write), 0);
    step();

    // Both requesters continuously pending for six transactions.
    i_read = 1; i_address = 32'h10;
    d_read = 1; d_write = 0; d_address = 32'h20;
    for (int t = 0; t < 6; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (t % 2) == 0;
`else
      exp_d = 1'b1;
`endif
      wait_grant($sformatf("tie%0d_grant", t));
      chk($sformatf("tie%0d_addr", t), mem_address, exp_d ? 32'h20 : 32'h10);
      mem_resp = 1; mem_rdata = 32'hA000_0000 + 32'(t);
      @(negedge clk);
      chk($sformatf("tie%0d_d_resp", t), 32'(d_resp), 32'(exp_d));
      chk($sformatf("tie%0d_i_resp", t), 32'(i_resp), 32'(!exp_d));
      step();
      mem_resp = 0;
      @(negedge clk);
      chk($sformatf("tie%0d_gap", t), 32'(mem_read | mem_write), 0);
      step();
    end
    i_read = 0; d_read = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
